keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Row-strobed key-matrix scanner with op-pin priority, scan-level debounce
// and a single-entry valid/ready output register.
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int NUM_OPS        = 7,
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 2,
  localparam int CW            = $clog2(ROWS*COLS+NUM_OPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [ROWS-1:0]     o_row_drive,
  input  logic [COLS-1:0]     i_col_sense,
  input  logic [NUM_OPS-1:0]  i_op_pins,
  output logic [CW-1:0]       o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_dropped,
  output logic                o_busy
);

  // state        | meaning
  // IDLE         | no key seen on the last scan
  // PRESS_QUAL   | candidate key seen, counting identical scans
  // HELD         | key qualified and latched, waiting for release
  // RELEASE_QUAL | empty scans seen, counting toward release/emit
  typedef enum logic [1:0] {IDLE, PRESS_QUAL, HELD, RELEASE_QUAL} state_t;

  localparam int NKEYS = ROWS*COLS;
  localparam int RW    = $clog2(ROWS);
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int QW    = $clog2(DEBOUNCE_SCANS+1);

  logic [RW-1:0] r;
  logic [SW-1:0] s;
  logic          sample, scan_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      s <= '0;
    end else if (sample) begin
      s <= '0;
      r <= (r == RW'(ROWS-1)) ? '0 : r + 1'b1;
    end else begin
      s <= s + 1'b1;
    end
  end

  assign sample      = (s == SW'(SETTLE_CYCLES-1));
  assign scan_end    = sample && (r == RW'(ROWS-1));
  assign o_row_drive = {{(ROWS-1){1'b0}}, 1'b1} << r;

  // Best closure on the current row: highest column, overridden by lowest op pin.
  logic          smp_vld, smp_op;
  logic [CW-1:0] smp_code;

  always_comb begin
    smp_vld  = 1'b0;
    smp_op   = 1'b0;
    smp_code = '0;
    for (int c = 0; c < COLS; c++) begin
      if (i_col_sense[c]) begin
        smp_vld  = 1'b1;
        smp_code = CW'(int'(r)*COLS + c);
      end
    end
    for (int k = NUM_OPS-1; k >= 0; k--) begin
      if (i_op_pins[k]) begin
        smp_vld  = 1'b1;
        smp_op   = 1'b1;
        smp_code = CW'(NKEYS + k);
      end
    end
  end

  logic          acc_vld, acc_op;
  logic [CW-1:0] acc_code;
  logic          mrg_vld, mrg_op;
  logic [CW-1:0] mrg_code;

  // Rows are visited in ascending order, so a later matrix hit always outranks an earlier one.
  always_comb begin
    mrg_vld  = acc_vld;
    mrg_op   = acc_op;
    mrg_code = acc_code;
    if (smp_vld) begin
      if (!acc_vld || (smp_op && (!acc_op || smp_code < acc_code)) || (!smp_op && !acc_op)) begin
        mrg_vld  = 1'b1;
        mrg_op   = smp_op;
        mrg_code = smp_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_vld  <= 1'b0;
      acc_op   <= 1'b0;
      acc_code <= '0;
    end else if (scan_end) begin
      acc_vld  <= 1'b0;
      acc_op   <= 1'b0;
      acc_code <= '0;
    end else if (sample) begin
      acc_vld  <= mrg_vld;
      acc_op   <= mrg_op;
      acc_code <= mrg_code;
    end
  end

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [CW-1:0] cand, cand_nxt, key, key_nxt;
  logic          emit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      qcnt  <= '0;
      cand  <= '0;
      key   <= '0;
    end else begin
      state <= state_nxt;
      qcnt  <= qcnt_nxt;
      cand  <= cand_nxt;
      key   <= key_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    cand_nxt  = cand;
    key_nxt   = key;
    emit      = 1'b0;
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (mrg_vld) begin
            if (DEBOUNCE_SCANS == 1) begin
              key_nxt   = mrg_code;
              state_nxt = HELD;
            end else begin
              cand_nxt  = mrg_code;
              qcnt_nxt  = QW'(1);
              state_nxt = PRESS_QUAL;
            end
          end
        end
        PRESS_QUAL: begin
          if (!mrg_vld) begin
            state_nxt = IDLE;
          end else if (mrg_code == cand) begin
            qcnt_nxt = qcnt + 1'b1;
            if (int'(qcnt) + 1 >= DEBOUNCE_SCANS) begin
              key_nxt   = cand;
              state_nxt = HELD;
            end
          end else begin
            cand_nxt = mrg_code;
            qcnt_nxt = QW'(1);
          end
        end
        HELD: begin
          if (!mrg_vld) begin
            qcnt_nxt = QW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              emit      = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = RELEASE_QUAL;
            end
          end
        end
        RELEASE_QUAL: begin
          if (mrg_vld) begin
            state_nxt = HELD;
          end else begin
            qcnt_nxt = qcnt + 1'b1;
            if (int'(qcnt) + 1 >= DEBOUNCE_SCANS) begin
              emit      = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_dropped <= 1'b0;
    end else begin
      o_dropped <= 1'b0;
      if (emit && (!o_valid || i_ready)) begin
        o_data  <= key;
        o_valid <= 1'b1;
      end else begin
        if (emit) o_dropped <= 1'b1;
        if (o_valid && i_ready) o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keyboard model answers the row strobe,
// directed scenarios plus randomized presses checked against a run-length debounce model.
module tb_keypad_scanner;
  localparam int ROWS = 4, COLS = 4, NOPS = 7, DB = 2, CW = 5, NK = ROWS*COLS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ROWS-1:0] row_drive;
  logic [COLS-1:0] col_sense;
  logic [NOPS-1:0] ops;
  logic [CW-1:0]   data;
  logic            valid, ready, dropped, busy;
  logic [NK-1:0]   mat;

  keypad_scanner dut (
    .clk(clk), .rst_n(rst_n), .o_row_drive(row_drive), .i_col_sense(col_sense),
    .i_op_pins(ops), .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_dropped(dropped), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_sense = '0;
    for (int r = 0; r < ROWS; r++)
      if (row_drive[r]) col_sense = col_sense | mat[r*COLS +: COLS];
  end

  int n_checks = 0, n_pass = 0;
  int sb[$];
  int drop_cnt = 0, hs_cnt = 0, exp_v;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Monitor: every accepted output must match the oldest expected key.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dropped) drop_cnt++;
      if (valid && ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got data %0d, expected no output", data);
        end else begin
          exp_v = sb.pop_front();
          check("sb_data", int'(data), exp_v);
        end
      end
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_scans(input int n);
    run_cycles(8*n);
  endtask

  task automatic press_release(input int code, input int hold, input int gap);
    mat = '0;
    mat[code] = 1'b1;
    run_scans(hold);
    mat = '0;
    run_scans(gap);
  endtask

  // Reference: op pins win (lowest index), else the highest matrix code.
  function automatic int scan_result(input logic [NK-1:0] m, input logic [NOPS-1:0] o);
    if (o != '0) begin
      for (int k = 0; k < NOPS; k++) if (o[k]) return NK + k;
    end
    for (int c = NK-1; c >= 0; c--) if (m[c]) return c;
    return -1;
  endfunction

  int m_streak, m_prev, m_rel, m_key;
  bit m_held;

  task automatic model_scan(input int res);
    if (!m_held) begin
      if (res < 0) m_streak = 0;
      else if (m_streak > 0 && res == m_prev) m_streak++;
      else m_streak = 1;
      m_prev = res;
      if (m_streak >= DB) begin
        m_held = 1'b1;
        m_key  = res;
        m_rel  = 0;
      end
    end else if (res < 0) begin
      m_rel++;
      if (m_rel >= DB) begin
        sb.push_back(m_key);
        m_held   = 1'b0;
        m_streak = 0;
      end
    end else begin
      m_rel = 0;
    end
  endtask

  int busy_cnt, hs_save, kind, hold, gap;

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    mat   = '0;
    ops   = '0;
    run_cycles(3);
    check("rst_row_drive", int'(row_drive), 1);
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dropped", int'(dropped), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      check("row_seq", int'(row_drive), 1 << ((i/2) % ROWS));
      run_cycles(1);
    end

    // Key 6 held 3 scans, released, consumer stalled.
    mat = '0; mat[6] = 1'b1;
    run_scans(3);
    mat = '0;
    run_scans(1);
    check("k6_not_yet", int'(valid), 0);
    sb.push_back(6);
    run_scans(1);
    check("k6_valid", int'(valid), 1);
    check("k6_data", int'(data), 6);
    check("k6_idle", int'(busy), 0);
    run_scans(2);
    check("k6_hold_valid", int'(valid), 1);
    check("k6_hold_data", int'(data), 6);
    ready = 1'b1;
    run_scans(1);
    check("k6_cleared", int'(valid), 0);

    // Op pin 4 together with matrix key 12.
    mat = '0; mat[12] = 1'b1; ops = 7'b0010000;
    run_scans(2);
    mat = '0; ops = '0;
    run_scans(1);
    sb.push_back(20);
    run_scans(1);
    check("op4_valid", int'(valid), 1);
    check("op4_data", int'(data), 20);
    run_scans(1);

    // Single-scan glitch.
    busy_cnt = 0;
    mat = '0; mat[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin run_cycles(1); busy_cnt += int'(busy); end
    mat = '0;
    for (int i = 0; i < 8; i++) begin run_cycles(1); busy_cnt += int'(busy); end
    check("glitch_busy_cycles", busy_cnt, 8);
    check("glitch_no_emit", int'(valid), 0);

    // Output full: drop, then reload on the accepting cycle.
    ready = 1'b0;
    sb.push_back(3);
    press_release(3, 2, 2);
    check("full_valid", int'(valid), 1);
    press_release(9, 2, 2);
    check("drop_pulse", int'(dropped), 1);
    check("drop_data_kept", int'(data), 3);
    run_scans(1);
    check("drop_count", drop_cnt, 1);
    press_release(9, 2, 1);
    run_cycles(7);
    ready = 1'b1;
    sb.push_back(9);
    run_cycles(1);
    ready = 1'b0;
    check("reload_valid", int'(valid), 1);
    check("reload_data", int'(data), 9);
    check("reload_no_drop", int'(dropped), 0);
    ready = 1'b1;
    run_scans(1);
    check("reload_drop_count", drop_cnt, 1);

    // Reset in the middle of release qualification.
    ready = 1'b0;
    press_release(5, 2, 2);
    check("pre_rst_valid", int'(valid), 1);
    press_release(2, 2, 1);
    run_cycles(3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_row", int'(row_drive), 1);
    sb.delete();
    run_cycles(2);
    rst_n = 1'b1;
    ready = 1'b1;
    hs_save = hs_cnt;
    run_scans(4);
    check("post_rst_no_emit", hs_cnt - hs_save, 0);
    check("post_rst_idle", int'(busy), 0);

    // Randomized presses against the reference model, consumer always ready.
    m_streak = 0; m_prev = -1; m_rel = 0; m_key = 0; m_held = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      kind = $urandom_range(0, 3);
      mat = '0; ops = '0;
      case (kind)
        0: mat[$urandom_range(0, NK-1)] = 1'b1;
        1: ops[$urandom_range(0, NOPS-1)] = 1'b1;
        2: begin
          mat = NK'($urandom);
          if ($urandom_range(0, 3) == 0) ops = NOPS'($urandom);
        end
        default: ;
      endcase
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        model_scan(scan_result(mat, ops));
        run_scans(1);
      end
      mat = '0; ops = '0;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        model_scan(-1);
        run_scans(1);
      end
    end
    for (int g = 0; g < DB + 1; g++) begin
      model_scan(-1);
      run_scans(1);
    end
    run_scans(1);
    check("sb_drained", sb.size(), 0);
    check("final_drop_count", drop_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
